us_flow_packetizer: RTL and testbench

//   Downstream stage of the upstream data-forwarding mux. Accepts the merged 128-bit timing/burst

---
 rtl/us_flow_packetizer.sv | 185 ++++++++++++++++++
 tb/tb_us_flow_packetizer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/us_flow_packetizer.sv
`default_nettype none
//==============================================================================
// Module : us_flow_packetizer
// Desc   : Buffers the merged 128-bit flow in a FIFO and frames it into
//          HEAD / payload / TAIL(checksum) packets on an AXI-Stream master.
// Rev    : 1.0  initial release
//==============================================================================
module us_flow_packetizer #(
  parameter int          FIFO_DEPTH       = 512,
  parameter int          PROG_FULL_THRESH = 448,
  parameter int          MAX_BEATS        = 64,
  parameter int          FLUSH_TIMEOUT    = 1024,
  parameter logic [15:0] SYNC_WORD        = 16'hEB90
) (
  input  logic                          sys_clk_i,
  input  logic                          rst_n_i,
  input  logic                          flow_vld_i,
  input  logic [127:0]                  flow_i,
  output logic                          flow_prog_full_o,
  output logic                          m_axis_tvalid_o,
  output logic [127:0]                  m_axis_tdata_o,
  output logic                          m_axis_tlast_o,
  input  logic                          m_axis_tready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [31:0]                   pkt_cnt_o,
  output logic                          overflow_o
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_tw = $clog2(FLUSH_TIMEOUT) + 1;

  localparam logic [c_aw:0]   c_depth      = (c_aw+1)'(FIFO_DEPTH);
  localparam logic [c_aw:0]   c_thresh     = (c_aw+1)'(PROG_FULL_THRESH);
  localparam logic [c_aw:0]   c_max_beats  = (c_aw+1)'(MAX_BEATS);
  localparam logic [c_aw:0]   c_lvl_one    = 1;
  localparam logic [c_aw-1:0] c_ptr_one    = 1;
  localparam logic [c_tw-1:0] c_timeout_m1 = c_tw'(FLUSH_TIMEOUT - 1);
  localparam logic [c_tw-1:0] c_tmr_one    = 1;

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_head    = 2'd1;
  localparam logic [1:0] c_st_payload = 2'd2;
  localparam logic [1:0] c_st_tail    = 2'd3;

  logic [127:0]    r_mem [FIFO_DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_level;
  logic            r_prog_full;
  logic            r_overflow;
  logic [1:0]      r_state;
  logic [c_tw-1:0] r_timer;
  logic [15:0]     r_len;
  logic [15:0]     r_beat;
  logic [15:0]     r_seq;
  logic [31:0]     r_csum;
  logic [31:0]     r_pkt_cnt;

  logic            w_full;
  logic            w_wr;
  logic            w_accept;
  logic            w_pop;
  logic            w_start;
  logic [c_aw:0]   w_len_lvl;
  logic [127:0]    w_rd_word;
  logic [31:0]     w_lane_sum;

  assign w_full     = (r_level == c_depth);
  assign w_wr       = flow_vld_i & ~w_full;
  assign w_accept   = m_axis_tvalid_o & m_axis_tready_i;
  assign w_pop      = w_accept & (r_state == c_st_payload);
  assign w_rd_word  = r_mem[r_rd_ptr];
  assign w_lane_sum = w_rd_word[31:0] + w_rd_word[63:32] + w_rd_word[95:64] + w_rd_word[127:96];
  assign w_len_lvl  = (r_level >= c_max_beats) ? c_max_beats : r_level;
  assign w_start    = (r_state == c_st_idle) &&
                      ((r_level >= c_max_beats) ||
                       ((r_level != '0) && (r_timer == c_timeout_m1)));

  // Storage is not reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge sys_clk_i) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= flow_i;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_prog_full <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + c_lvl_one;
        2'b01:   r_level <= r_level - c_lvl_one;
        default: r_level <= r_level;
      endcase
      if (flow_vld_i && w_full) begin
        r_overflow <= 1'b1;
      end
      r_prog_full <= (r_level >= c_thresh);
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_timer <= '0;
    end else if ((r_state != c_st_idle) || (r_level == '0) ||
                 (r_level >= c_max_beats) || w_start) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + c_tmr_one;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= c_st_idle;
      r_len     <= '0;
      r_beat    <= '0;
      r_seq     <= '0;
      r_csum    <= '0;
      r_pkt_cnt <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_start) begin
            r_state <= c_st_head;
            r_len   <= 16'(w_len_lvl);
            r_beat  <= '0;
            r_csum  <= '0;
          end
        end
        c_st_head: begin
          if (w_accept) begin
            r_state <= c_st_payload;
          end
        end
        c_st_payload: begin
          if (w_accept) begin
            r_csum <= r_csum + w_lane_sum;
            r_beat <= r_beat + 16'd1;
            if (r_beat == r_len - 16'd1) begin
              r_state <= c_st_tail;
            end
          end
        end
        default: begin
          if (w_accept) begin
            r_state   <= c_st_idle;
            r_seq     <= r_seq + 16'd1;
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
          end
        end
      endcase
    end
  end

  // Output beat is a pure function of state so reset removes tvalid at once.
  always_comb begin
    m_axis_tdata_o = '0;
    case (r_state)
      c_st_head:    m_axis_tdata_o = {SYNC_WORD, r_seq, r_len, 80'd0};
      c_st_payload: m_axis_tdata_o = w_rd_word;
      c_st_tail:    m_axis_tdata_o = {SYNC_WORD, r_seq, r_len, 48'd0, r_csum};
      default:      m_axis_tdata_o = '0;
    endcase
  end

  assign m_axis_tvalid_o  = (r_state != c_st_idle);
  assign m_axis_tlast_o   = (r_state == c_st_tail);
  assign flow_prog_full_o = r_prog_full;
  assign fifo_level_o     = r_level;
  assign pkt_cnt_o        = r_pkt_cnt;
  assign overflow_o       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_us_flow_packetizer.sv
`default_nettype none
//==============================================================================
// Module : tb_us_flow_packetizer
// Desc   : Randomized bench for us_flow_packetizer with a queue-based model.
// Rev    : 1.0  initial release
//==============================================================================
module tb_us_flow_packetizer;

  localparam int          DEPTH  = 512;
  localparam int          THRESH = 448;
  localparam int          MAXB   = 64;
  localparam int          TMO    = 1024;
  localparam logic [15:0] SYNC   = 16'hEB90;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         vld = 1'b0;
  logic         rdy = 1'b0;
  logic [127:0] din = '0;
  logic         prog_full;
  logic         tvalid;
  logic [127:0] tdata;
  logic         tlast;
  logic [9:0]   level;
  logic [31:0]  pkt_cnt;
  logic         overflow;

  always #5 clk = ~clk;

  us_flow_packetizer #(
    .FIFO_DEPTH       (DEPTH),
    .PROG_FULL_THRESH (THRESH),
    .MAX_BEATS        (MAXB),
    .FLUSH_TIMEOUT    (TMO),
    .SYNC_WORD        (SYNC)
  ) dut (
    .sys_clk_i        (clk),
    .rst_n_i          (rst_n),
    .flow_vld_i       (vld),
    .flow_i           (din),
    .flow_prog_full_o (prog_full),
    .m_axis_tvalid_o  (tvalid),
    .m_axis_tdata_o   (tdata),
    .m_axis_tlast_o   (tlast),
    .m_axis_tready_i  (rdy),
    .fifo_level_o     (level),
    .pkt_cnt_o        (pkt_cnt),
    .overflow_o       (overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] lanes(input logic [127:0] w);
    return w[31:0] + w[63:32] + w[95:64] + w[127:96];
  endfunction

  // Reference model: FIFO contents as a queue, stream parsed packet by packet.
  logic [127:0] q[$];
  logic [15:0]  exp_seq;
  logic [31:0]  exp_pkt;
  logic         m_ovf, m_pf, m_full;
  int           ps, rem;
  logic [15:0]  cur_len;
  logic [31:0]  sum;
  logic         hold_pend;
  logic [127:0] hold_data;
  logic         hold_last;
  int           idle_run, max_gap, n_beats;
  logic         after_tail;
  logic [127:0] w_exp;
  int           log_len[$];
  int           log_seq[$];
  logic [31:0]  log_sum[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        exp_seq = '0; exp_pkt = '0; m_ovf = 1'b0; m_pf = 1'b0;
        ps = 0; rem = 0; sum = '0; cur_len = '0;
        hold_pend = 1'b0; after_tail = 1'b0; idle_run = 0;
      end else begin
        chk("level", level, q.size());
        chk("pkt_cnt", pkt_cnt, exp_pkt);
        chk("overflow", overflow, m_ovf);
        chk("prog_full", prog_full, m_pf);
        if (hold_pend) begin
          chk("hold_valid", tvalid, 1);
          chk("hold_data", tdata, hold_data);
          chk("hold_last", tlast, hold_last);
        end
        hold_pend = tvalid && !rdy;
        hold_data = tdata;
        hold_last = tlast;
        m_full = (q.size() == DEPTH);
        m_pf   = (q.size() >= THRESH);
        if (tvalid && rdy) begin
          n_beats++;
          if (ps == 0) begin
            cur_len = tdata[95:80];
            chk("head_sync", tdata[127:112], SYNC);
            chk("head_seq", tdata[111:96], exp_seq);
            chk("head_len_ok", (cur_len >= 1) && (cur_len <= MAXB) && (cur_len <= q.size()), 1);
            chk("head_pad", tdata[79:0], 0);
            chk("head_last", tlast, 0);
            if (after_tail && idle_run > max_gap) max_gap = idle_run;
            after_tail = 1'b0;
            sum = '0;
            rem = int'(cur_len);
            ps  = (rem == 0) ? 2 : 1;
          end else if (ps == 1) begin
            if (q.size() == 0) begin
              chk("payload_underrun", 1, 0);
            end else begin
              w_exp = q.pop_front();
              chk("payload", tdata, w_exp);
              sum = sum + lanes(w_exp);
            end
            chk("payload_last", tlast, 0);
            rem--;
            if (rem == 0) ps = 2;
          end else begin
            chk("tail", tdata, {SYNC, exp_seq, cur_len, 48'd0, sum});
            chk("tail_last", tlast, 1);
            log_len.push_back(int'(cur_len));
            log_seq.push_back(int'(exp_seq));
            log_sum.push_back(sum);
            exp_seq = exp_seq + 16'd1;
            exp_pkt = exp_pkt + 32'd1;
            after_tail = 1'b1;
            ps = 0;
          end
        end
        if (tvalid) idle_run = 0;
        else idle_run++;
        if (vld) begin
          if (m_full) m_ovf = 1'b1;
          else q.push_back(din);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [127:0] d, input logic r);
    @(posedge clk);
    #1;
    vld = v; din = d; rdy = r;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; vld = 1'b0; rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    log_len.delete(); log_seq.delete(); log_sum.delete();
    n_beats = 0; max_gap = 0;
  endtask

  task automatic wait_idle(input logic rnd, input int bound);
    logic done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      cyc(1'b0, '0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (level == 0 && !tvalid) done = 1'b1;
    end
    chk("idle_reached", done, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           cnt;
    int           tot;
    logic         seen;
    logic [31:0]  kk;
    int           t3_len[4] = '{64, 64, 64, 8};

    // reset state
    @(posedge clk);
    #1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_level", level, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_prog_full", prog_full, 0);

    // 1: one full packet of counting words, HEAD latency
    do_reset();
    for (int k = 0; k < 64; k++) begin
      kk = k;
      cyc(1'b1, {kk, kk, kk, kk}, 1'b1);
    end
    cyc(1'b0, '0, 1'b1);
    chk("t1_lat_n1", tvalid, 0);
    cyc(1'b0, '0, 1'b1);
    chk("t1_lat_n2", tvalid, 1);
    chk("t1_head_len", tdata[95:80], 64);
    wait_idle(1'b0, 200);
    chk("t1_beats", n_beats, 66);
    chk("t1_npkt", log_len.size(), 1);
    if (log_len.size() >= 1) begin
      chk("t1_len", log_len[0], 64);
      chk("t1_seq", log_seq[0], 0);
      chk("t1_csum", log_sum[0], 32'h1F80);
    end
    chk("t1_pkt_cnt", pkt_cnt, 1);

    // 2: partial packet flushed after the idle timeout
    do_reset();
    cnt = 0;
    for (int i = 0; i < TMO; i++) begin
      cyc(i < 10, rnd128(), 1'b1);
      if (tvalid) cnt++;
    end
    chk("t2_quiet", cnt, 0);
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      cyc(1'b0, '0, 1'b1);
      if (tvalid) begin
        seen = 1'b1;
        chk("t2_head_len", tdata[95:80], 10);
      end
    end
    chk("t2_head_seen", seen, 1);
    wait_idle(1'b0, 64);
    chk("t2_npkt", log_len.size(), 1);
    if (log_len.size() >= 1) chk("t2_len", log_len[0], 10);
    chk("t2_level", level, 0);

    // 3: 200 words under random backpressure
    do_reset();
    for (int i = 0; i < 200; i++) cyc(1'b1, rnd128(), 1'($urandom_range(0, 1)));
    wait_idle(1'b1, 4000);
    chk("t3_npkt", log_len.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_len.size()) begin
        chk("t3_len", log_len[i], t3_len[i]);
        chk("t3_seq", log_seq[i], i);
      end
    end

    // 4: overflow with the stream stalled
    do_reset();
    for (int k = 0; k < 520; k++) begin
      cyc(1'b1, rnd128(), 1'b0);
      if (k == 512) begin
        chk("t4_lvl_512", level, 512);
        chk("t4_no_ovf_yet", overflow, 0);
      end
    end
    cyc(1'b0, '0, 1'b0);
    chk("t4_level_sat", level, 512);
    chk("t4_overflow", overflow, 1);
    chk("t4_prog_full", prog_full, 1);
    wait_idle(1'b0, 1500);
    chk("t4_npkt", log_len.size(), 8);
    tot = 0;
    foreach (log_len[i]) tot += log_len[i];
    chk("t4_words", tot, 512);

    // 5: reset in the middle of a payload
    do_reset();
    for (int k = 0; k < 64; k++) cyc(1'b1, rnd128(), 1'b1);
    repeat (32) cyc(1'b0, '0, 1'b1);
    chk("t5_in_payload", tvalid && !tlast, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_tvalid", tvalid, 0);
    chk("t5_rst_level", level, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    log_len.delete(); log_seq.delete(); log_sum.delete();
    for (int k = 0; k < 64; k++) cyc(1'b1, rnd128(), 1'b1);
    wait_idle(1'b0, 200);
    chk("t5_npkt", log_len.size(), 1);
    if (log_seq.size() >= 1) chk("t5_seq", log_seq[0], 0);
    chk("t5_pkt_cnt", pkt_cnt, 1);

    // 6: continuous writes while packets stream back to back
    do_reset();
    for (int i = 0; i < 400; i++) cyc(1'b1, rnd128(), 1'b1);
    chk("t6_gap", max_gap <= 1, 1);
    chk("t6_npkt", log_len.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < log_len.size()) chk("t6_len", log_len[i], 64);
    end
    wait_idle(1'b0, 2500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
